// File: rtl/sdram_byte_reader_if.sv
// -----------------------------------------------------------------------------
// sdram_byte_reader_if
//
// Bundles the Avalon-style az_/za_ signals between a read master and the
// SDRAM controller.
//
//   az_addr        master -> ctrl  word address
//   az_be_n        master -> ctrl  byte enables, active low
//   az_cs          master -> ctrl  chip select
//   az_rd_n        master -> ctrl  read request, active low
//   az_wr_n        master -> ctrl  write request, active low
//   az_data        master -> ctrl  write data
//   za_data        ctrl -> master  read-return data
//   za_valid       ctrl -> master  read-return strobe
//   za_waitrequest ctrl -> master  stall; request is not taken while high
// -----------------------------------------------------------------------------
interface sdram_byte_reader_if #(
  parameter int ADDR_WIDTH = 22
);
  logic [ADDR_WIDTH-1:0] az_addr;
  logic [1:0]            az_be_n;
  logic                  az_cs;
  logic                  az_rd_n;
  logic                  az_wr_n;
  logic [15:0]           az_data;
  logic [15:0]           za_data;
  logic                  za_valid;
  logic                  za_waitrequest;

  modport master (
    output az_addr, az_be_n, az_cs, az_rd_n, az_wr_n, az_data,
    input  za_data, za_valid, za_waitrequest
  );

  modport slave (
    input  az_addr, az_be_n, az_cs, az_rd_n, az_wr_n, az_data,
    output za_data, za_valid, za_waitrequest
  );
endinterface

// File: rtl/sdram_byte_reader.sv
// -----------------------------------------------------------------------------
// sdram_byte_reader
//
// Reads 1-4 bytes starting at an arbitrary byte address from a 16-bit SDRAM
// controller. Issues pipelined word reads, collects the in-order returns and
// assembles a little-endian 32-bit result. Used for opcode/operand fetch and
// LOAD execution.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      request strobe, only looked at while busy = 0
//   byte_addr  starting byte address (ADDR_WIDTH+1 bits)
//   len_m1     byte count minus one
//   busy       transfer in progress, or post-reset flush
//   done       one-cycle pulse, rd_data valid
//   rd_data    result; byte at byte_addr in [7:0], unused upper bytes zero
//   sdram      master side of the controller interface
//
// After reset the block stays busy for FLUSH_CYCLES so that read returns
// belonging to an abandoned transfer drain before a new one starts; the
// controller offers no way to cancel reads already in flight.
// -----------------------------------------------------------------------------
module sdram_byte_reader #(
  parameter int ADDR_WIDTH   = 22,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   byte_addr,
  input  logic [1:0]            len_m1,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rd_data,
  sdram_byte_reader_if.master   sdram
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic                  rd_n_q,      rd_n_d;
  logic                  lsb_q,       lsb_d;
  logic [1:0]            len_q,       len_d;
  logic [1:0]            nwords_q,    nwords_d;
  logic [1:0]            issued_q,    issued_d;
  logic [1:0]            recv_q,      recv_d;
  // Assembly buffer. The top byte of the third word can never land in the
  // 32-bit result (a third word only exists for odd addresses, which shift
  // the buffer down by one byte), so only 40 of the 48 bits are kept.
  logic [39:0]           buf_q,       buf_d;
  logic [31:0]           rd_data_q,   rd_data_d;
  logic                  done_q,      done_d;

  logic                  accept;
  logic                  capture;
  logic [2:0]            nw_sum;

  // Select the requested bytes out of the collected words and zero the rest.
  function automatic logic [31:0] assemble(input logic [39:0] b,
                                           input logic        lsb,
                                           input logic [1:0]  len);
    logic [31:0] w;
    w = lsb ? b[39:8] : b[31:0];
    for (int i = 0; i < 4; i++) begin
      if (i > int'(len)) w[8*i +: 8] = 8'h00;
    end
    return w;
  endfunction

  // Words needed to cover len_m1+1 bytes starting at an even or odd byte.
  assign nw_sum = {2'b00, byte_addr[0]} + {1'b0, len_m1} + 3'd2;

  // A request is taken by the controller on any edge with rd_n low and no stall.
  assign accept = !rd_n_q && !sdram.za_waitrequest;

  // Returns are only meaningful while a transfer is open; anything seen in
  // FLUSH or IDLE is a leftover from an abandoned transfer.
  assign capture = sdram.za_valid
                && ((state_q == ST_ISSUE) || (state_q == ST_WAIT))
                && (recv_q != nwords_q);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    addr_d      = addr_q;
    rd_n_d      = rd_n_q;
    lsb_d       = lsb_q;
    len_d       = len_q;
    nwords_d    = nwords_q;
    issued_d    = issued_q;
    recv_d      = recv_q;
    buf_d       = buf_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;

    // Return k lands in buffer bits [16k+15:16k]; capture runs in parallel
    // with issuing so a return coinciding with the last acceptance is kept.
    if (capture) begin
      case (recv_q)
        2'd0:    buf_d[15:0]  = sdram.za_data;
        2'd1:    buf_d[31:16] = sdram.za_data;
        2'd2:    buf_d[39:32] = sdram.za_data[7:0];
        default: ;
      endcase
      recv_d = recv_q + 2'd1;
    end

    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
        else                           flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
      end

      ST_IDLE: begin
        if (start) begin
          lsb_d    = byte_addr[0];
          len_d    = len_m1;
          nwords_d = 2'(nw_sum >> 1);
          issued_d = 2'd0;
          recv_d   = 2'd0;
          buf_d    = '0;
          addr_d   = byte_addr[ADDR_WIDTH:1];
          rd_n_d   = 1'b0;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Address and rd_n only move on acceptance, so they hold through stalls.
        if (accept) begin
          if (issued_q == nwords_q - 2'd1) begin
            rd_n_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            issued_d = issued_q + 2'd1;
            addr_d   = addr_q + ADDR_WIDTH'(1);   // wraps at 2^ADDR_WIDTH
          end
        end
      end

      ST_WAIT: begin
        if (recv_d == nwords_q) begin
          rd_data_d = assemble(buf_d, lsb_q, len_q);
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_FLUSH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      addr_q      <= '0;
      rd_n_q      <= 1'b1;
      lsb_q       <= 1'b0;
      len_q       <= 2'd0;
      nwords_q    <= 2'd0;
      issued_q    <= 2'd0;
      recv_q      <= 2'd0;
      buf_q       <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      addr_q      <= addr_d;
      rd_n_q      <= rd_n_d;
      lsb_q       <= lsb_d;
      len_q       <= len_d;
      nwords_q    <= nwords_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      buf_q       <= buf_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign rd_data = rd_data_q;

  assign sdram.az_addr = addr_q;
  assign sdram.az_rd_n = rd_n_q;
  assign sdram.az_be_n = 2'b00;
  assign sdram.az_cs   = 1'b1;
  assign sdram.az_wr_n = 1'b1;
  assign sdram.az_data = 16'h0000;

endmodule

// File: tb/tb_sdram_byte_reader.sv
// -----------------------------------------------------------------------------
// tb_sdram_byte_reader
//
// Drives sdram_byte_reader against a behavioural SDRAM controller with a
// configurable fixed read latency and optional stalls. Expected results come
// from a byte-level memory model; a monitor compares them when done pulses
// and checks every accepted request address.
// -----------------------------------------------------------------------------
module tb_sdram_byte_reader;

  localparam int AW    = 22;
  localparam int FLUSH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   byte_addr;
  logic [1:0]    len_m1;
  logic          busy;
  logic          done;
  logic [31:0]   rd_data;

  always #5 clk = ~clk;

  sdram_byte_reader_if #(.ADDR_WIDTH(AW)) bus ();

  sdram_byte_reader #(
    .ADDR_WIDTH   (AW),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byte_addr (byte_addr),
    .len_m1    (len_m1),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .sdram     (bus.master)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Memory and reference model
  // ---------------------------------------------------------------------------
  logic [15:0] mem_ovr [int unsigned];

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return (a[15:0] * 16'h9E37) ^ {10'b0, a[21:16]} ^ 16'h5A5A;
  endfunction

  // Byte i of the result is memory byte (ba + i) mod 2^(AW+1).
  function automatic logic [31:0] ref_read(input logic [AW:0] ba, input logic [1:0] len);
    logic [31:0] r;
    logic [AW:0] b;
    logic [15:0] w;
    r = '0;
    for (int i = 0; i <= int'(len); i++) begin
      b = ba + (AW+1)'(i);
      w = mem_word(b[AW:1]);
      r[8*i +: 8] = b[0] ? w[15:8] : w[7:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  logic [31:0]   exp_q [$];
  logic [AW-1:0] exp_addr_q [$];

  // ---------------------------------------------------------------------------
  // Controller model (acts on the falling edge; decides what the DUT will see
  // at the following rising edge)
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  ret_t          rq [$];
  ret_t          ret_head;
  int            cyc = 0;
  int            lat = 3;
  bit            rand_stall = 1'b0;
  int            stall_cnt_total = 0;
  int            stall_until = 0;
  int            acc_total = 0;
  int            txn_base = 0;
  int            n_done = 0;
  logic          prev_wait = 1'b0;
  logic          prev_rd_n = 1'b1;
  logic          prev_rst  = 1'b1;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    // While a request is stalled it must be held unchanged.
    if (prev_wait === 1'b1 && prev_rd_n === 1'b0 && prev_rst === 1'b0) begin
      check("stall_hold_rd_n", 64'(bus.az_rd_n), 64'd0);
      check("stall_hold_addr", 64'(bus.az_addr), 64'(prev_addr));
    end

    bus.za_valid = 1'b0;
    bus.za_data  = 16'($urandom);
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      ret_head     = rq.pop_front();
      bus.za_valid = 1'b1;
      bus.za_data  = ret_head.data;
    end

    if (bus.az_rd_n === 1'b0 && (acc_total - txn_base) == 1 && stall_cnt_total < stall_until) begin
      bus.za_waitrequest = 1'b1;
      stall_cnt_total++;
    end else begin
      bus.za_waitrequest = rand_stall && ($urandom_range(0, 3) == 0);
    end

    if (bus.az_rd_n === 1'b0 && !bus.za_waitrequest) begin
      rq.push_back('{due: cyc + lat, data: mem_word(bus.az_addr)});
      if (reset === 1'b0) begin
        acc_total++;
        if (exp_addr_q.size() == 0) fail($sformatf("extra_request addr=0x%0h", bus.az_addr));
        else check("req_addr", 64'(bus.az_addr), 64'(exp_addr_q.pop_front()));
      end
    end

    prev_wait = bus.za_waitrequest;
    prev_rd_n = bus.az_rd_n;
    prev_addr = bus.az_addr;
    prev_rst  = reset;
  end

  // ---------------------------------------------------------------------------
  // Result monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) fail($sformatf("unexpected_done rd_data=0x%0h", rd_data));
      else begin
        check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    if (busy !== 1'b0) fail("idle_timeout");
  endtask

  task automatic issue(input logic [AW:0] ba, input logic [1:0] len,
                       input bit use_const, input logic [31:0] cexp);
    logic [AW:0]   b;
    logic [AW-1:0] last;
    bit            have;
    wait_idle();
    have = 1'b0;
    last = '0;
    for (int i = 0; i <= int'(len); i++) begin
      b = ba + (AW+1)'(i);
      if (!have || b[AW:1] != last) exp_addr_q.push_back(b[AW:1]);
      last = b[AW:1];
      have = 1'b1;
    end
    exp_q.push_back(use_const ? cexp : ref_read(ba, len));
    txn_base  = acc_total;
    start     = 1'b1;
    byte_addr = ba;
    len_m1    = len;
    step();
    start     = 1'b0;
    byte_addr = (AW+1)'($urandom);
    len_m1    = 2'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      fail("done_timeout");
      exp_q.delete();
    end
    if (exp_addr_q.size() > 0) begin
      fail("missing_request");
      exp_addr_q.delete();
    end
  endtask

  task automatic check_flush(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check(name, 64'(n), 64'(FLUSH));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int          done_before;
  logic [AW:0] rba;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    byte_addr = '0;
    len_m1    = 2'd0;

    mem_ovr[8]  = 16'h2211;
    mem_ovr[9]  = 16'h4433;
    mem_ovr[10] = 16'h6655;
    mem_ovr[1]  = 16'hBBAA;

    repeat (3) step();
    check("rst_busy",    64'(busy),        64'd1);
    check("rst_done",    64'(done),        64'd0);
    check("rst_rd_data", 64'(rd_data),     64'd0);
    check("rst_rd_n",    64'(bus.az_rd_n), 64'd1);
    check("rst_addr",    64'(bus.az_addr), 64'd0);
    check("rst_wr_n",    64'(bus.az_wr_n), 64'd1);
    check("rst_be_n",    64'(bus.az_be_n), 64'd0);
    check("rst_cs",      64'(bus.az_cs),   64'd1);
    reset = 1'b0;
    check_flush("flush_after_reset");

    // Directed fetches
    issue(23'h000010, 2'd3, 1'b1, 32'h44332211);
    wait_drain();
    issue(23'h000011, 2'd3, 1'b1, 32'h55443322);
    wait_drain();
    issue(23'h000003, 2'd0, 1'b1, 32'h000000BB);
    wait_drain();

    // Five-cycle stall on the second request
    stall_until = stall_cnt_total + 5;
    issue(23'h000041, 2'd3, 1'b0, 32'h0);
    wait_drain();
    check("stall_cycles_seen", 64'(stall_cnt_total), 64'(stall_until));

    // Word-address wrap plus start while busy
    done_before = n_done;
    issue(23'h7FFFFF, 2'd1, 1'b0, 32'h0);
    check("busy_after_start", 64'(busy), 64'd1);
    start     = 1'b1;
    byte_addr = 23'h000100;
    len_m1    = 2'd3;
    repeat (3) step();
    start     = 1'b0;
    wait_drain();
    repeat (10) step();
    check("single_done", 64'(n_done - done_before), 64'd1);

    // Reset once the first request has been accepted
    lat = 2;
    done_before = n_done;
    issue(23'h000020, 2'd3, 1'b0, 32'h0);
    begin
      int n = 0;
      while (acc_total == txn_base && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (acc_total == txn_base) fail("first_accept_timeout");
    end
    step();
    reset = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    step();
    check("midrst_rd_n", 64'(bus.az_rd_n), 64'd1);
    check("midrst_busy", 64'(busy),        64'd1);
    check("midrst_done", 64'(done),        64'd0);
    reset = 1'b0;
    check_flush("flush_after_midrst");
    check("midrst_no_done", 64'(n_done - done_before), 64'd0);
    issue(23'h000120, 2'd3, 1'b0, 32'h0);
    wait_drain();

    // Randomized fetches with random stalls and latencies
    rand_stall = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wait_idle();
      lat = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) rba = 23'h7FFFFC + (AW+1)'($urandom_range(0, 3));
      else                           rba = (AW+1)'($urandom);
      issue(rba, 2'($urandom), 1'b0, 32'h0);
      if ($urandom_range(0, 1) == 0) wait_drain();
    end
    wait_drain();
    rand_stall = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
